exu_fpu_issue_ctl: RTL and testbench

EXU_FPU_ISSUE_CTL -- requirements
Module: exu_fpu_issue_ctl

---
 rtl/exu_fpu_issue_ctl.sv | 175 +++++++++++++++++
 tb/tb_exu_fpu_issue_ctl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_fpu_issue_ctl.sv
// exu_fpu_issue_ctl -- FPU issue control.
//
// Purpose: buffers FP requests in an in-order queue, offers the head entry to
// the FP datapath with a cap on in-flight operations, registers returning
// results, and accrues sticky exception flags.
//
// Ports:
//   clk, rst_l                 clock, synchronous active-low reset
//   req_*                      request side (valid/ready, operands, op, rm, tag)
//   dp_valid/dp_ready, dp_*    head entry offered to the datapath
//   dp_out_*                   result returning from the datapath
//   flush / dp_flush           pipeline flush in, forwarded to the datapath
//   result_valid/result/tag    registered result (one-cycle pulse)
//   fflags / fflags_clr        sticky NV/DZ/OF/UF/NX flags and their clear
//   busy, stall                status
//
// Configuration: define RV_FPU_FFLAGS_EN to enable fflags accrual; otherwise
// fflags is tied to 0 and fflags_clr / dp_status are ignored.

module exu_fpu_issue_ctl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0] req_c,
    input  logic [3:0]       req_op,
    input  logic [2:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    output logic             dp_valid,
    input  logic             dp_ready,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic [WIDTH-1:0] dp_c,
    output logic [3:0]       dp_op,
    output logic [2:0]       dp_rm,
    output logic [TAG_W-1:0] dp_tag,
    input  logic             dp_out_valid,
    input  logic [WIDTH-1:0] dp_result,
    input  logic [4:0]       dp_status,
    input  logic [TAG_W-1:0] dp_out_tag,
    input  logic             flush,
    output logic             dp_flush,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] result_tag,
    output logic [4:0]       fflags,
    input  logic             fflags_clr,
    output logic             busy,
    output logic             stall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // queue storage (data only, validity lives in count_q)
    logic [WIDTH-1:0] mem_a_q   [DEPTH];
    logic [WIDTH-1:0] mem_b_q   [DEPTH];
    logic [WIDTH-1:0] mem_c_q   [DEPTH];
    logic [3:0]       mem_op_q  [DEPTH];
    logic [2:0]       mem_rm_q  [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, outst_q, outst_d;
    logic             result_valid_q, result_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [TAG_W-1:0] result_tag_q, result_tag_d;
    logic [4:0]       fflags_q, fflags_d;
    logic             enq, deq, cap;

    // Gating with rst_l keeps the handshakes quiet while reset is held.
    assign req_ready = rst_l & (count_q < CNT_W'(DEPTH)) & ~flush;
    assign dp_valid  = rst_l & (count_q != '0) & (outst_q < CNT_W'(DEPTH)) & ~flush;
    assign busy      = rst_l & ((count_q != '0) | (outst_q != '0));
    assign stall     = ~req_ready;
    assign dp_flush  = flush;

    assign enq = req_valid & req_ready;
    assign deq = dp_valid & dp_ready;
    assign cap = dp_out_valid & ~flush;

    assign dp_a   = mem_a_q[rd_ptr_q];
    assign dp_b   = mem_b_q[rd_ptr_q];
    assign dp_c   = mem_c_q[rd_ptr_q];
    assign dp_op  = mem_op_q[rd_ptr_q];
    assign dp_rm  = mem_rm_q[rd_ptr_q];
    assign dp_tag = mem_tag_q[rd_ptr_q];

    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign result_tag   = result_tag_q;
    assign fflags       = fflags_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        outst_d  = outst_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            outst_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by overflow
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (enq & ~deq)      count_d = count_q + CNT_W'(1);
            else if (~enq & deq) count_d = count_q - CNT_W'(1);
            // a stray result with nothing outstanding saturates at zero
            if (deq & ~cap)                        outst_d = outst_q + CNT_W'(1);
            else if (~deq & cap && outst_q != '0)  outst_d = outst_q - CNT_W'(1);
        end
    end

    always_comb begin
        result_valid_d = cap;
        result_d       = cap ? dp_result  : result_q;
        result_tag_d   = cap ? dp_out_tag : result_tag_q;
    end

`ifdef RV_FPU_FFLAGS_EN
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr)
            fflags_d = cap ? dp_status : 5'd0;   // clear, then the new result's flags
        else if (cap)
            fflags_d = fflags_q | dp_status;
    end
`else
    logic unused_fflags_in;
    assign unused_fflags_in = ^{fflags_clr, dp_status};
    always_comb fflags_d = 5'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            outst_q        <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            result_tag_q   <= '0;
            fflags_q       <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            outst_q        <= outst_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            result_tag_q   <= result_tag_d;
            fflags_q       <= fflags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_a_q[wr_ptr_q]   <= req_a;
            mem_b_q[wr_ptr_q]   <= req_b;
            mem_c_q[wr_ptr_q]   <= req_c;
            mem_op_q[wr_ptr_q]  <= req_op;
            mem_rm_q[wr_ptr_q]  <= req_rm;
            mem_tag_q[wr_ptr_q] <= req_tag;
        end
    end

endmodule

// File: tb/tb_exu_fpu_issue_ctl.sv
// Directed bench for exu_fpu_issue_ctl (WIDTH=32, DEPTH=4, TAG_W=3).
// Inputs change 1 time unit after posedge; checks happen 2 units later.

module tb_exu_fpu_issue_ctl;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b, req_c;
    logic [3:0]  req_op;
    logic [2:0]  req_rm, req_tag;
    logic        dp_valid, dp_ready;
    logic [31:0] dp_a, dp_b, dp_c;
    logic [3:0]  dp_op;
    logic [2:0]  dp_rm, dp_tag;
    logic        dp_out_valid;
    logic [31:0] dp_result;
    logic [4:0]  dp_status;
    logic [2:0]  dp_out_tag;
    logic        flush, dp_flush;
    logic        result_valid;
    logic [31:0] result;
    logic [2:0]  result_tag;
    logic [4:0]  fflags;
    logic        fflags_clr, busy, stall;

    int n_cmp = 0;
    int n_err = 0;
    int disp;

    always #5 clk = ~clk;

    exu_fpu_issue_ctl #(.WIDTH(32), .DEPTH(4), .TAG_W(3)) dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_op(req_op), .req_rm(req_rm), .req_tag(req_tag),
        .dp_valid(dp_valid), .dp_ready(dp_ready),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
        .dp_op(dp_op), .dp_rm(dp_rm), .dp_tag(dp_tag),
        .dp_out_valid(dp_out_valid), .dp_result(dp_result),
        .dp_status(dp_status), .dp_out_tag(dp_out_tag),
        .flush(flush), .dp_flush(dp_flush),
        .result_valid(result_valid), .result(result), .result_tag(result_tag),
        .fflags(fflags), .fflags_clr(fflags_clr),
        .busy(busy), .stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic req(input logic [2:0] tag, input logic [31:0] a);
        req_valid = 1'b1;
        req_tag   = tag;
        req_a     = a;
        req_b     = a + 32'd1;
        req_op    = 4'(tag);
    endtask

    task automatic ret(input logic [2:0] tag, input logic [31:0] r, input logic [4:0] st);
        dp_out_valid = 1'b1;
        dp_out_tag   = tag;
        dp_result    = r;
        dp_status    = st;
    endtask

    initial begin
        logic [4:0] ff_exp;
        rst_l = 1'b0; req_valid = 1'b1; req_a = '0; req_b = '0; req_c = '0;
        req_op = '0; req_rm = '0; req_tag = '0; dp_ready = 1'b1;
        dp_out_valid = 1'b0; dp_result = '0; dp_status = '0; dp_out_tag = '0;
        flush = 1'b0; fflags_clr = 1'b0;

        // ---- reset ----
        cyc(); cyc(); settle();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_stall", 32'(stall), 1);
        chk("rst_dp_valid", 32'(dp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_fflags", 32'(fflags), 0);
        req_valid = 1'b0; dp_ready = 1'b0;
        rst_l = 1'b1;
        cyc();

        // ---- single op ----
        req(3'd2, 32'h3F800000); req_b = 32'h40000000; dp_ready = 1'b1;
        settle();
        chk("single_req_ready", 32'(req_ready), 1);
        chk("single_no_bypass", 32'(dp_valid), 0);
        cyc(); req_valid = 1'b0; settle();
        chk("single_dp_valid", 32'(dp_valid), 1);
        chk("single_dp_a", dp_a, 32'h3F800000);
        chk("single_dp_b", dp_b, 32'h40000000);
        chk("single_dp_tag", 32'(dp_tag), 2);
        cyc(); dp_ready = 1'b0; settle();
        chk("single_inflight_busy", 32'(busy), 1);
        chk("single_dp_idle", 32'(dp_valid), 0);
        ret(3'd2, 32'h40400000, 5'h01); settle();
        chk("single_res_not_yet", 32'(result_valid), 0);
        cyc(); dp_out_valid = 1'b0; settle();
        chk("single_res_valid", 32'(result_valid), 1);
        chk("single_result", result, 32'h40400000);
        chk("single_res_tag", 32'(result_tag), 2);
        chk("single_busy_done", 32'(busy), 0);
`ifdef RV_FPU_FFLAGS_EN
        ff_exp = 5'h01;
`else
        ff_exp = 5'h00;
`endif
        chk("single_fflags", 32'(fflags), 32'(ff_exp));
        cyc(); settle();
        chk("single_pulse_end", 32'(result_valid), 0);
        chk("single_result_hold", result, 32'h40400000);

        // ---- full queue, ordered drain, in-flight cap ----
        for (int i = 0; i < 4; i++) begin
            req(3'(i), 32'(100 + i)); settle();
            chk($sformatf("full_ready_%0d", i), 32'(req_ready), 1);
            cyc();
        end
        req(3'd4, 32'd104); settle();
        chk("full_ready_low", 32'(req_ready), 0);
        chk("full_stall", 32'(stall), 1);
        dp_ready = 1'b1; settle();
        chk("drain_tag0", 32'(dp_tag), 0);
        chk("drain_a0", dp_a, 32'd100);
        cyc(); settle();
        chk("fifth_ready", 32'(req_ready), 1);
        chk("drain_tag1", 32'(dp_tag), 1);
        cyc(); req_valid = 1'b0; settle();
        chk("drain_tag2", 32'(dp_tag), 2);
        cyc(); settle();
        chk("drain_tag3", 32'(dp_tag), 3);
        cyc(); settle();
        chk("cap_blocks", 32'(dp_valid), 0);
        chk("cap_busy", 32'(busy), 1);
        ret(3'd0, 32'h11, 5'h00); settle();
        chk("cap_blocks_ret", 32'(dp_valid), 0);
        cyc(); dp_out_valid = 1'b0; settle();
        chk("cap_release", 32'(dp_valid), 1);
        chk("fifth_tag", 32'(dp_tag), 4);
        chk("fifth_a", dp_a, 32'd104);
        cyc(); dp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ret(3'(i + 1), 32'(200 + i), 5'h00);
            cyc();
        end
        dp_out_valid = 1'b0; settle();
        chk("drain_busy", 32'(busy), 0);
        chk("drain_last_tag", 32'(result_tag), 4);

        // ---- in-flight cap with 6 back-to-back requests ----
        disp = 0; dp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 6) req(3'(k), 32'(300 + k));
            else req_valid = 1'b0;
            settle();
            if (dp_valid && dp_ready) disp++;
            cyc();
        end
        chk("cap_dispatches", 32'(disp), 4);
        settle();
        chk("cap_dp_low", 32'(dp_valid), 0);
        ret(3'd0, 32'h22, 5'h00); cyc(); dp_out_valid = 1'b0; settle();
        chk("cap_fifth_valid", 32'(dp_valid), 1);
        chk("cap_fifth_tag", 32'(dp_tag), 4);
        cyc(); dp_ready = 1'b0;
        flush = 1'b1; settle();
        chk("flushA_dp_flush", 32'(dp_flush), 1);
        cyc(); flush = 1'b0; settle();
        chk("flushA_busy", 32'(busy), 0);

        // ---- flush: 3 queued, 2 outstanding, result in flush cycle ----
        req(3'd0, 32'd400); cyc();
        req(3'd1, 32'd401); cyc();
        dp_ready = 1'b1;
        req(3'd2, 32'd402); cyc();
        req(3'd3, 32'd403); cyc();
        dp_ready = 1'b0;
        req(3'd4, 32'd404); cyc();
        req_valid = 1'b0;
        flush = 1'b1; ret(3'd7, 32'hDEAD, 5'h1F); settle();
        chk("flush_dp_flush", 32'(dp_flush), 1);
        chk("flush_dp_valid", 32'(dp_valid), 0);
        chk("flush_req_ready", 32'(req_ready), 0);
        cyc(); flush = 1'b0; dp_out_valid = 1'b0; settle();
        chk("flush_no_result", 32'(result_valid), 0);
        chk("flush_result_hold", result, 32'h22);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_ready", 32'(req_ready), 1);
        chk("flush_dp_empty", 32'(dp_valid), 0);
        chk("flush_fflags", 32'(fflags), 32'(ff_exp));
        // outstanding cleared: 4 fresh dispatches allowed
        dp_ready = 1'b1; disp = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) req(3'(k), 32'(500 + k));
            else req_valid = 1'b0;
            settle();
            if (dp_valid && dp_ready) disp++;
            cyc();
        end
        chk("flush_outst_zero", 32'(disp), 4);
        dp_ready = 1'b0;
        flush = 1'b1; cyc(); flush = 1'b0;

        // ---- fflags accrual / clear ----
        fflags_clr = 1'b1; cyc(); fflags_clr = 1'b0;
        ret(3'd1, 32'h1, 5'h01); cyc();
        ret(3'd2, 32'h2, 5'h04); cyc();
        dp_out_valid = 1'b0; settle();
`ifdef RV_FPU_FFLAGS_EN
        ff_exp = 5'h05;
`else
        ff_exp = 5'h00;
`endif
        chk("fflags_or", 32'(fflags), 32'(ff_exp));
        chk("saturate_busy", 32'(busy), 0);
        ret(3'd3, 32'h3, 5'h10); fflags_clr = 1'b1; cyc();
        dp_out_valid = 1'b0; fflags_clr = 1'b0; settle();
`ifdef RV_FPU_FFLAGS_EN
        ff_exp = 5'h10;
`else
        ff_exp = 5'h00;
`endif
        chk("fflags_clr_set", 32'(fflags), 32'(ff_exp));
        chk("fflags_res_tag", 32'(result_tag), 3);

        // ---- reset mid-operation ----
        req(3'd5, 32'd600); cyc();
        req(3'd6, 32'd601); cyc(); req_valid = 1'b0;
        rst_l = 1'b0; ret(3'd5, 32'h77, 5'h02); settle();
        chk("midrst_ready", 32'(req_ready), 0);
        chk("midrst_dp_valid", 32'(dp_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        cyc(); rst_l = 1'b1; settle();
        chk("midrst_no_result", 32'(result_valid), 0);
        chk("midrst_result_clr", result, 0);
        chk("midrst_fflags_clr", 32'(fflags), 0);
        cyc(); dp_out_valid = 1'b0; settle();
        chk("postrst_capture", 32'(result_valid), 1);
        chk("postrst_result", result, 32'h77);
        chk("postrst_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
